// File: rtl/result_banner_pkg.sv
// Shared constants for the result banner overlay: colours, modes, FSM states, glyph codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: RGB565 colours, mode/state encodings, 4-bit character codes,
//           5-character message tables and small lookup helpers.
package result_banner_pkg;

  // RGB565 colours
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

  // Result modes; the reserved code behaves like PAUSE everywhere
  localparam logic [1:0] MODE_WIN   = 2'd0;
  localparam logic [1:0] MODE_LOSE  = 2'd1;
  localparam logic [1:0] MODE_PAUSE = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTRO = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  // Character codes understood by banner_font_rom
  localparam logic [3:0] CH_SP = 4'd0;
  localparam logic [3:0] CH_W  = 4'd1;
  localparam logic [3:0] CH_I  = 4'd2;
  localparam logic [3:0] CH_N  = 4'd3;
  localparam logic [3:0] CH_EX = 4'd4;
  localparam logic [3:0] CH_L  = 4'd5;
  localparam logic [3:0] CH_O  = 4'd6;
  localparam logic [3:0] CH_S  = 4'd7;
  localparam logic [3:0] CH_E  = 4'd8;
  localparam logic [3:0] CH_P  = 4'd9;
  localparam logic [3:0] CH_A  = 4'd10;
  localparam logic [3:0] CH_U  = 4'd11;

  // Messages, leftmost character in the top nibble
  localparam logic [19:0] MSG_WIN   = {CH_SP, CH_W, CH_I, CH_N, CH_EX};
  localparam logic [19:0] MSG_LOSE  = {CH_L, CH_O, CH_S, CH_E, CH_EX};
  localparam logic [19:0] MSG_PAUSE = {CH_P, CH_A, CH_U, CH_S, CH_E};

  function automatic logic [19:0] msg_for(input logic [1:0] m);
    case (m)
      MODE_WIN:  return MSG_WIN;
      MODE_LOSE: return MSG_LOSE;
      default:   return MSG_PAUSE;
    endcase
  endfunction

  function automatic logic [3:0] msg_char(input logic [1:0] m, input logic [2:0] idx);
    logic [19:0] msg;
    msg = msg_for(m);
    case (idx)
      3'd0:    return msg[19:16];
      3'd1:    return msg[15:12];
      3'd2:    return msg[11:8];
      3'd3:    return msg[7:4];
      3'd4:    return msg[3:0];
      default: return CH_SP;
    endcase
  endfunction

  function automatic logic [15:0] fill_colour(input logic [1:0] m);
    case (m)
      MODE_WIN:  return RGB_GREEN;
      MODE_LOSE: return RGB_RED;
      default:   return RGB_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/banner_font_rom.sv
// 5x7 glyph row lookup for the banner character set.
// Latency: combinational.
// Backpressure: none.
// Ports: char_code - 4-bit character code; row - glyph row 0..7 (row 7 blank);
//        row_bits - 5-bit row bitmap, MSB is the leftmost column.
module banner_font_rom
  import result_banner_pkg::*;
(
  input  logic [3:0] char_code,
  input  logic [2:0] row,
  output logic [4:0] row_bits
);

  // Whole glyph, row 0 in the top 5 bits
  logic [34:0] glyph;

  always_comb begin
    glyph = '0;
    case (char_code)
      CH_W:  glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
      CH_I:  glyph = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      CH_N:  glyph = {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b10001};
      CH_EX: glyph = {5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00100};
      CH_L:  glyph = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
      CH_O:  glyph = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      CH_S:  glyph = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
      CH_E:  glyph = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
      CH_P:  glyph = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
      CH_A:  glyph = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      CH_U:  glyph = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
      default: glyph = '0;
    endcase
  end

  always_comb begin
    row_bits = '0;
    case (row)
      3'd0:    row_bits = glyph[34:30];
      3'd1:    row_bits = glyph[29:25];
      3'd2:    row_bits = glyph[24:20];
      3'd3:    row_bits = glyph[19:15];
      3'd4:    row_bits = glyph[14:10];
      3'd5:    row_bits = glyph[9:5];
      3'd6:    row_bits = glyph[4:0];
      default: row_bits = '0;
    endcase
  end

endmodule

// File: rtl/result_banner_display.sv
// Animated result banner overlaid on a background RGB565 pixel stream.
// Latency: 2 vga_clk cycles from pix_x/pix_y/bg_data to pix_data.
// Backpressure: none; the pixel stream advances every cycle.
// Ports: vga_clk/sys_rst_n clock and async active-low reset; pix_x/pix_y/bg_data
//        incoming pixel; show/mode banner request; pix_data composited pixel;
//        banner_active high in INTRO/SHOW; intro_done pulse on INTRO->SHOW.
module result_banner_display
  import result_banner_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BOX_X        = 240,
  parameter int BOX_Y        = 180,
  parameter int BOX_W        = 160,
  parameter int BOX_H        = 70,
  parameter int BORDER_W     = 2,
  parameter int SCALE_LOG2   = 1,
  parameter int REVEAL_STEP  = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [15:0] bg_data,
  input  logic        show,
  input  logic [1:0]  mode,
  output logic [15:0] pix_data,
  output logic        banner_active,
  output logic        intro_done
);

  localparam int SCALE = 1 << SCALE_LOG2;
  // Text block is centred; horizontally 5 cells of 6 columns, vertically the 7 glyph rows
  localparam int TXT_X = BOX_X + (BOX_W - 30 * SCALE) / 2;
  localparam int TXT_Y = BOX_Y + (BOX_H - 7 * SCALE) / 2;
  localparam int RW_W  = $clog2(BOX_W + REVEAL_STEP + 1);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] X_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] BOX_X0 = 10'(BOX_X);
  localparam logic [9:0] BOX_X1 = 10'(BOX_X + BOX_W);
  localparam logic [9:0] BOX_Y0 = 10'(BOX_Y);
  localparam logic [9:0] BOX_Y1 = 10'(BOX_Y + BOX_H);
  localparam logic [9:0] TXT_X0 = 10'(TXT_X);
  localparam logic [9:0] TXT_X1 = 10'(TXT_X + 30 * SCALE);
  localparam logic [9:0] TXT_Y0 = 10'(TXT_Y);
  localparam logic [9:0] TXT_Y1 = 10'(TXT_Y + 8 * SCALE);

  // ---------------------------------------------------------------- frame tick
  logic at_end, at_end_q, frame_tick;
  assign at_end     = (pix_x == X_END) && (pix_y == Y_END);
  assign frame_tick = at_end && !at_end_q;

  // ---------------------------------------------------------------- control
  state_e            state;
  logic [RW_W-1:0]   reveal_w;
  logic [RW_W-1:0]   reveal_next;
  logic [BC_W-1:0]   blink_cnt;
  logic              blink_phase;
  logic [1:0]        mode_q;

  assign reveal_next = reveal_w + RW_W'(REVEAL_STEP);

  // All control state moves only at the frame boundary so a frame never tears
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_IDLE;
      reveal_w      <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      mode_q        <= MODE_WIN;
      banner_active <= 1'b0;
      intro_done    <= 1'b0;
      at_end_q      <= 1'b0;
    end else begin
      at_end_q   <= at_end;
      intro_done <= 1'b0;
      if (frame_tick) begin
        case (state)
          ST_IDLE: begin
            if (show) begin
              mode_q        <= mode;
              reveal_w      <= '0;
              state         <= ST_INTRO;
              banner_active <= 1'b1;
            end
          end
          ST_INTRO: begin
            if (!show) begin
              state         <= ST_IDLE;
              reveal_w      <= '0;
              banner_active <= 1'b0;
            end else if (reveal_next >= RW_W'(BOX_W)) begin
              reveal_w   <= RW_W'(BOX_W);
              state      <= ST_SHOW;
              intro_done <= 1'b1;
              blink_cnt  <= '0;
              blink_phase <= 1'b0;
            end else begin
              reveal_w <= reveal_next;
            end
          end
          ST_SHOW: begin
            if (!show) begin
              state         <= ST_IDLE;
              reveal_w      <= '0;
              blink_cnt     <= '0;
              blink_phase   <= 1'b0;
              banner_active <= 1'b0;
            end else begin
              mode_q <= mode;
              if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          default: begin
            state         <= ST_IDLE;
            banner_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [9:0] box_rx, box_ry, txt_rx, txt_ry;
  logic       in_box, revealed, vis, in_border, in_txt;
  logic [4:0] tcol;
  logic [2:0] trow;
  logic [2:0] cidx, gcol;

  assign box_rx = pix_x - BOX_X0;
  assign box_ry = pix_y - BOX_Y0;
  assign txt_rx = pix_x - TXT_X0;
  assign txt_ry = pix_y - TXT_Y0;

  assign in_box   = (pix_x >= BOX_X0) && (pix_x < BOX_X1) &&
                    (pix_y >= BOX_Y0) && (pix_y < BOX_Y1);
  assign revealed = (state == ST_SHOW) || (16'(box_rx) < 16'(reveal_w));
  assign vis      = in_box && revealed && (state != ST_IDLE);

  assign in_border = (box_rx < 10'(BORDER_W)) || (box_rx >= 10'(BOX_W - BORDER_W)) ||
                     (box_ry < 10'(BORDER_W)) || (box_ry >= 10'(BOX_H - BORDER_W));

  assign in_txt = (pix_x >= TXT_X0) && (pix_x < TXT_X1) &&
                  (pix_y >= TXT_Y0) && (pix_y < TXT_Y1);

  // Unscaled text column 0..29 and row 0..7
  assign tcol = 5'(txt_rx >> SCALE_LOG2);
  assign trow = 3'(txt_ry >> SCALE_LOG2);

  // Split the text column into character cell and column within the 6-wide cell
  always_comb begin
    cidx = 3'd0;
    gcol = 3'(tcol);
    if (tcol >= 5'd24) begin
      cidx = 3'd4;
      gcol = 3'(tcol - 5'd24);
    end else if (tcol >= 5'd18) begin
      cidx = 3'd3;
      gcol = 3'(tcol - 5'd18);
    end else if (tcol >= 5'd12) begin
      cidx = 3'd2;
      gcol = 3'(tcol - 5'd12);
    end else if (tcol >= 5'd6) begin
      cidx = 3'd1;
      gcol = 3'(tcol - 5'd6);
    end
  end

  logic        s1_vis, s1_border, s1_in_txt, s1_border_white;
  logic [2:0]  s1_cidx, s1_grow, s1_gcol;
  logic [1:0]  s1_mode;
  logic [15:0] s1_bg;

  // Mode and border colour travel with the pixel so the frame edge lines up exactly
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_vis          <= 1'b0;
      s1_border       <= 1'b0;
      s1_in_txt       <= 1'b0;
      s1_border_white <= 1'b0;
      s1_cidx         <= '0;
      s1_grow         <= '0;
      s1_gcol         <= '0;
      s1_mode         <= '0;
      s1_bg           <= '0;
    end else begin
      s1_vis          <= vis;
      s1_border       <= in_border;
      s1_in_txt       <= in_txt;
      s1_border_white <= (state == ST_SHOW) && blink_phase;
      s1_cidx         <= cidx;
      s1_grow         <= trow;
      s1_gcol         <= gcol;
      s1_mode         <= mode_q;
      s1_bg           <= bg_data;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [3:0] s2_char;
  logic [4:0] s2_row_bits;
  logic       glyph_bit;

  assign s2_char = msg_char(s1_mode, s1_cidx);

  banner_font_rom u_font (
    .char_code (s2_char),
    .row       (s1_grow),
    .row_bits  (s2_row_bits)
  );

  // Cell column 5 is the inter-character gap
  always_comb begin
    glyph_bit = 1'b0;
    case (s1_gcol)
      3'd0:    glyph_bit = s2_row_bits[4];
      3'd1:    glyph_bit = s2_row_bits[3];
      3'd2:    glyph_bit = s2_row_bits[2];
      3'd3:    glyph_bit = s2_row_bits[1];
      3'd4:    glyph_bit = s2_row_bits[0];
      default: glyph_bit = 1'b0;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data <= '0;
    end else if (!s1_vis) begin
      pix_data <= s1_bg;
    end else if (s1_border) begin
      pix_data <= s1_border_white ? RGB_WHITE : RGB_YELLOW;
    end else if (s1_in_txt && glyph_bit) begin
      pix_data <= RGB_WHITE;
    end else begin
      pix_data <= fill_colour(s1_mode);
    end
  end

endmodule
